// File: rtl/gmii_word_packer.sv
// GMII receive byte packer: strips preamble/SFD and packs payload bytes into DATA_W-bit words.
// Define GMII_PACKER_FRAME_CNT_EN to add saturating good-frame and error counters.
module gmii_word_packer #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          gmii_rxd_i,
    input  logic                gmii_rx_dv_i,
    input  logic                gmii_rx_er_i,
    output logic [DATA_W-1:0]   data_o,
    output logic [DATA_W/8+3:0] status_o
`ifdef GMII_PACKER_FRAME_CNT_EN
    ,
    output logic [15:0]         frame_cnt_o,
    output logic [15:0]         err_cnt_o
`endif
);

    localparam int LANES    = DATA_W / 8;
    localparam int STATUS_W = LANES + 4;
    localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {
        DROP,
        IDLE,
        PREAMBLE,
        PAYLOAD
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          pre_cnt_q, pre_cnt_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic                full_q, full_d;
    logic                sof_q, sof_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   acc_q, acc_d;

    logic                vld_p0;
    logic                eof_p0;
    logic                pre_drop_p0;
    logic [LANES-1:0]    keep_p0;
    logic [STATUS_W-1:0] status_p0;

    logic [DATA_W-1:0]   data_p1;
    logic [STATUS_W-1:0] status_p1;

    // Stage p0: frame FSM, lane accumulation and emit decision
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        lane_d      = lane_q;
        full_d      = full_q;
        sof_d       = sof_q;
        err_d       = err_q;
        acc_d       = acc_q;
        vld_p0      = 1'b0;
        eof_p0      = 1'b0;
        pre_drop_p0 = 1'b0;

        case (state_q)
            DROP: begin
                if (!gmii_rx_dv_i) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (gmii_rx_dv_i) begin
                    if (gmii_rxd_i == 8'h55) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end

            PREAMBLE: begin
                if (!gmii_rx_dv_i) begin
                    state_d = IDLE;
                end else if (gmii_rxd_i == 8'h55) begin
                    if (pre_cnt_q >= 4'd7) begin
                        state_d     = DROP;
                        pre_drop_p0 = 1'b1;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end else if (gmii_rxd_i == 8'hD5) begin
                    state_d = PAYLOAD;
                    lane_d  = '0;
                    full_d  = 1'b0;
                    sof_d   = 1'b1;
                    err_d   = 1'b0;
                    acc_d   = '0;
                end else begin
                    state_d     = DROP;
                    pre_drop_p0 = 1'b1;
                end
            end

            PAYLOAD: begin
                if (!gmii_rx_dv_i) begin
                    // An SFD immediately followed by dv=0 has nothing buffered and emits nothing
                    if (full_q || (lane_q != '0)) begin
                        vld_p0 = 1'b1;
                        eof_p0 = 1'b1;
                    end
                    state_d = IDLE;
                    lane_d  = '0;
                    full_d  = 1'b0;
                end else begin
                    // A completed word waits here until the next byte proves it is not the last
                    if (full_q) begin
                        vld_p0 = 1'b1;
                        sof_d  = 1'b0;
                        full_d = 1'b0;
                        acc_d  = '0;
                    end
                    acc_d[{lane_q, 3'b000} +: 8] = gmii_rxd_i;
                    if (gmii_rx_er_i) begin
                        err_d = 1'b1;
                    end
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        full_d = 1'b1;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end

            default: state_d = DROP;
        endcase

        keep_p0   = (eof_p0 && !full_q) ? LANES'((1 << lane_q) - 1) : '1;
        status_p0 = vld_p0 ? {keep_p0, err_q & eof_p0, eof_p0, sof_q, 1'b1} : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DROP;
            pre_cnt_q <= '0;
            lane_q    <= '0;
            full_q    <= 1'b0;
            sof_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            lane_q    <= lane_d;
            full_q    <= full_d;
            sof_q     <= sof_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    // Stage p1: registered word and status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p1   <= '0;
            status_p1 <= '0;
        end else begin
            status_p1 <= status_p0;
            if (vld_p0) begin
                data_p1 <= acc_q;
            end
        end
    end

    assign data_o   = data_p1;
    assign status_o = status_p1;

`ifdef GMII_PACKER_FRAME_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (vld_p0 && eof_p0 && !err_q) begin
                frame_cnt_q <= sat_inc(frame_cnt_q);
            end
            if ((vld_p0 && eof_p0 && err_q) || pre_drop_p0) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_gmii_word_packer.sv
// Directed bench for gmii_word_packer (DATA_W=32): preamble handling, packing, eof/keep, errors, reset.
module tb_gmii_word_packer;

    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  gmii_rxd_i;
    logic        gmii_rx_dv_i;
    logic        gmii_rx_er_i;
    logic [31:0] data_o;
    logic [7:0]  status_o;
`ifdef GMII_PACKER_FRAME_CNT_EN
    logic [15:0] frame_cnt_o;
    logic [15:0] err_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gmii_word_packer #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .gmii_rxd_i   (gmii_rxd_i),
        .gmii_rx_dv_i (gmii_rx_dv_i),
        .gmii_rx_er_i (gmii_rx_er_i),
        .data_o       (data_o),
        .status_o     (status_o)
`ifdef GMII_PACKER_FRAME_CNT_EN
        ,
        .frame_cnt_o  (frame_cnt_o),
        .err_cnt_o    (err_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one byte time, then check status just after the edge that sampled it
    task automatic step(input logic dv, input logic er, input logic [7:0] d,
                        input logic [7:0] exp_st, input string tag);
        gmii_rx_dv_i = dv;
        gmii_rx_er_i = er;
        gmii_rxd_i   = d;
        @(posedge clk);
        #1;
        chk(tag, 32'(status_o), 32'(exp_st));
    endtask

    task automatic preamble(input logic er_pre);
        for (int i = 0; i < 7; i++) step(1'b1, er_pre, 8'h55, 8'h00, "pre");
        step(1'b1, er_pre, 8'hD5, 8'h00, "sfd");
    endtask

    initial begin
        rst          = 1'b0;
        gmii_rx_dv_i = 1'b0;
        gmii_rx_er_i = 1'b0;
        gmii_rxd_i   = 8'h00;
        #12;
        chk("rst_status", 32'(status_o), 32'h0);
        chk("rst_data", data_o, 32'h0);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 8'h00, "idle0");
        step(1'b0, 1'b0, 8'h00, 8'h00, "idle1");

        // Payload error on byte 3: err only on the eof word
        preamble(1'b0);
        step(1'b1, 1'b0, 8'h11, 8'h00, "e_b1");
        step(1'b1, 1'b0, 8'h12, 8'h00, "e_b2");
        step(1'b1, 1'b1, 8'h13, 8'h00, "e_b3");
        step(1'b1, 1'b0, 8'h14, 8'h00, "e_b4");
        step(1'b1, 1'b0, 8'h15, 8'hF3, "e_w1_status");
        chk("e_w1_data", data_o, 32'h14131211);
        step(1'b1, 1'b0, 8'h16, 8'h00, "e_b6");
        step(1'b1, 1'b0, 8'h17, 8'h00, "e_b7");
        step(1'b1, 1'b0, 8'h18, 8'h00, "e_b8");
        step(1'b0, 1'b0, 8'h00, 8'hFD, "e_eof_status");
        chk("e_eof_data", data_o, 32'h18171615);
`ifdef GMII_PACKER_FRAME_CNT_EN
        chk("e_err_cnt", 32'(err_cnt_o), 32'd1);
        chk("e_frame_cnt", 32'(frame_cnt_o), 32'd0);
`endif

        // Basic 8-byte frame
        preamble(1'b0);
        step(1'b1, 1'b0, 8'h01, 8'h00, "a_b1");
        step(1'b1, 1'b0, 8'h02, 8'h00, "a_b2");
        step(1'b1, 1'b0, 8'h03, 8'h00, "a_b3");
        step(1'b1, 1'b0, 8'h04, 8'h00, "a_b4");
        step(1'b1, 1'b0, 8'h05, 8'hF3, "a_w1_status");
        chk("a_w1_data", data_o, 32'h04030201);
        step(1'b1, 1'b0, 8'h06, 8'h00, "a_b6");
        step(1'b1, 1'b0, 8'h07, 8'h00, "a_b7");
        step(1'b1, 1'b0, 8'h08, 8'h00, "a_b8");
        step(1'b0, 1'b0, 8'h00, 8'hF5, "a_eof_status");
        chk("a_eof_data", data_o, 32'h08070605);
        step(1'b0, 1'b0, 8'h00, 8'h00, "a_after");
        chk("a_data_hold", data_o, 32'h08070605);

        // 5-byte frame, er during preamble must be ignored
        preamble(1'b1);
        step(1'b1, 1'b0, 8'hAA, 8'h00, "b_b1");
        step(1'b1, 1'b0, 8'hBB, 8'h00, "b_b2");
        step(1'b1, 1'b0, 8'hCC, 8'h00, "b_b3");
        step(1'b1, 1'b0, 8'hBB, 8'h00, "b_b4");
        step(1'b1, 1'b0, 8'hAA, 8'hF3, "b_w1_status");
        chk("b_w1_data", data_o, 32'hBBCCBBAA);
        step(1'b0, 1'b0, 8'h00, 8'h15, "b_eof_status");
        chk("b_eof_data", data_o, 32'h000000AA);

        // SFD then dv=0: nothing emitted
        preamble(1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, "empty_eof");
        step(1'b0, 1'b0, 8'h00, 8'h00, "empty_after");

        // Bad preamble byte, then over-long preamble: both dropped
        step(1'b1, 1'b0, 8'h55, 8'h00, "bp_1");
        step(1'b1, 1'b0, 8'h55, 8'h00, "bp_2");
        step(1'b1, 1'b0, 8'h12, 8'h00, "bp_3");
        step(1'b1, 1'b0, 8'hD5, 8'h00, "bp_4");
        step(1'b1, 1'b1, 8'h34, 8'h00, "bp_5");
        step(1'b0, 1'b0, 8'h00, 8'h00, "bp_end");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h55, 8'h00, "lp_pre");
        step(1'b1, 1'b0, 8'hD5, 8'h00, "lp_sfd");
        step(1'b1, 1'b0, 8'h01, 8'h00, "lp_b1");
        step(1'b1, 1'b0, 8'h02, 8'h00, "lp_b2");
        step(1'b0, 1'b0, 8'h00, 8'h00, "lp_end");
        preamble(1'b0);
        step(1'b1, 1'b0, 8'h01, 8'h00, "g_b1");
        step(1'b1, 1'b0, 8'h02, 8'h00, "g_b2");
        step(1'b1, 1'b0, 8'h03, 8'h00, "g_b3");
        step(1'b0, 1'b0, 8'h00, 8'h77, "g_eof_status");
        chk("g_eof_data", data_o, 32'h00030201);

        // Back-to-back frames with a single dv=0 gap
        preamble(1'b0);
        step(1'b1, 1'b0, 8'hA1, 8'h00, "f1_b1");
        step(1'b1, 1'b0, 8'hA2, 8'h00, "f1_b2");
        step(1'b1, 1'b0, 8'hA3, 8'h00, "f1_b3");
        step(1'b1, 1'b0, 8'hA4, 8'h00, "f1_b4");
        step(1'b0, 1'b0, 8'h00, 8'hF7, "f1_eof_status");
        chk("f1_eof_data", data_o, 32'hA4A3A2A1);
        preamble(1'b0);
        step(1'b1, 1'b0, 8'hB1, 8'h00, "f2_b1");
        step(1'b1, 1'b0, 8'hB2, 8'h00, "f2_b2");
        step(1'b0, 1'b0, 8'h00, 8'h37, "f2_eof_status");
        chk("f2_eof_data", data_o, 32'h0000B2B1);
`ifdef GMII_PACKER_FRAME_CNT_EN
        chk("mid_frame_cnt", 32'(frame_cnt_o), 32'd5);
        chk("mid_err_cnt", 32'(err_cnt_o), 32'd3);
`endif

        // Reset in the middle of a frame, released while dv is still high
        preamble(1'b0);
        step(1'b1, 1'b0, 8'h01, 8'h00, "r_b1");
        step(1'b1, 1'b0, 8'h02, 8'h00, "r_b2");
        step(1'b1, 1'b0, 8'h03, 8'h00, "r_b3");
        step(1'b1, 1'b0, 8'h04, 8'h00, "r_b4");
        step(1'b1, 1'b0, 8'h05, 8'hF3, "r_w1_status");
        step(1'b1, 1'b0, 8'h06, 8'h00, "r_b6");
        gmii_rxd_i = 8'h07;
        #2;
        rst = 1'b0;
        #1;
        chk("r_async_status", 32'(status_o), 32'h0);
        chk("r_async_data", data_o, 32'h0);
        #3;
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h07, 8'h00, "r_drop1");
        step(1'b1, 1'b0, 8'h08, 8'h00, "r_drop2");
        step(1'b1, 1'b0, 8'h09, 8'h00, "r_drop3");
        step(1'b0, 1'b0, 8'h00, 8'h00, "r_drop_end");
        preamble(1'b0);
        step(1'b1, 1'b0, 8'h01, 8'h00, "n_b1");
        step(1'b1, 1'b0, 8'h02, 8'h00, "n_b2");
        step(1'b1, 1'b0, 8'h03, 8'h00, "n_b3");
        step(1'b1, 1'b0, 8'h04, 8'h00, "n_b4");
        step(1'b1, 1'b0, 8'h05, 8'hF3, "n_w1_status");
        chk("n_w1_data", data_o, 32'h04030201);
        step(1'b0, 1'b0, 8'h00, 8'h15, "n_eof_status");
        chk("n_eof_data", data_o, 32'h00000005);
`ifdef GMII_PACKER_FRAME_CNT_EN
        chk("n_frame_cnt", 32'(frame_cnt_o), 32'd1);
        chk("n_err_cnt", 32'(err_cnt_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
